// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, flush-to-bubble.
// Optional perf counters (stall_cnt, bubble_cnt) when PIPE_SKID_STAGE_PERF_EN is defined.
module pipe_skid_stage #(
    parameter int unsigned           WIDTH  = 41,
    parameter logic [WIDTH-1:0]      BUBBLE = 41'h0_0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
`ifdef PIPE_SKID_STAGE_PERF_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt,
`endif
    output logic [1:0]       occupancy
);

    // state | meaning
    // EMPTY | no beat held; main holds BUBBLE
    // ONE   | main holds the oldest beat, skid holds BUBBLE
    // FULL  | main holds the oldest beat, skid holds the next one
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             fire;

    // Handshake outputs decode registered state only, so no ready/valid ripple.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = out_valid ? main_q : BUBBLE;

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (accept && !fire) begin
                        state_q <= FULL;
                        skid_q  <= in_data;
                    end else if (accept && fire) begin
                        main_q  <= in_data;
                    end else if (fire) begin
                        state_q <= EMPTY;
                        main_q  <= BUBBLE;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    main_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STAGE_PERF_EN
    // flush while upstream is blocked is a debug clear pattern, not a real event.
    logic perf_clr;
    assign perf_clr = flush & in_valid & ~in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && !flush && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage; perf-counter checks when PIPE_SKID_STAGE_PERF_EN is defined.
module tb_pipe_skid_stage;

    localparam int unsigned      WIDTH  = 41;
    localparam logic [WIDTH-1:0] BUBBLE = 41'h0_0000_0013;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       occupancy;
`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_skid_stage #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
`ifdef PIPE_SKID_STAGE_PERF_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat into a stalled stage.
    task automatic push(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_occ",       64'(occupancy), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(BUBBLE));
        rst_n = 1'b1;
        step();
        chk("idle_occ", 64'(occupancy), 64'(0));

        // Streaming: each beat appears one cycle after it is offered.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = WIDTH'(i);
            step();
            chk("stream_data",  64'(out_data),  64'(i));
            chk("stream_occ",   64'(occupancy), 64'(1));
            chk("stream_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_occ", 64'(occupancy), 64'(0));
        chk("stream_drain_data", 64'(out_data), 64'(BUBBLE));

        // Stall and skid.
        out_ready = 1'b0;
        push(41'h11);
        push(41'h22);
        chk("skid_occ",      64'(occupancy), 64'(2));
        chk("skid_in_ready", 64'(in_ready),  64'(0));
        chk("skid_data",     64'(out_data),  64'(41'h11));
        step();
        chk("skid_hold_data", 64'(out_data), 64'(41'h11));
        out_ready = 1'b1;
        step();
        chk("skid_fire2_data", 64'(out_data),  64'(41'h22));
        chk("skid_in_ready1",  64'(in_ready),  64'(1));
        chk("skid_occ1",       64'(occupancy), 64'(1));
        step();
        chk("skid_empty_occ",   64'(occupancy), 64'(0));
        chk("skid_empty_valid", 64'(out_valid), 64'(0));

        // Flush in FULL with a pending input beat.
        out_ready = 1'b0;
        push(41'hA1);
        push(41'hA2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 41'h33;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_occ",  64'(occupancy), 64'(0));
        chk("flush_full_data", 64'(out_data),  64'(BUBBLE));
        out_ready = 1'b1;
        step();
        chk("flush_no33_valid", 64'(out_valid), 64'(0));

        // Flush in ONE beats a simultaneous accept and fire.
        out_ready = 1'b0;
        push(41'h5A);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 41'h66;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_occ",  64'(occupancy), 64'(0));
        chk("flush_one_data", 64'(out_data),  64'(BUBBLE));

        // Simultaneous accept and fire in ONE.
        out_ready = 1'b0;
        push(41'h44);
        chk("af_pre_data", 64'(out_data), 64'(41'h44));
        in_valid  = 1'b1;
        in_data   = 41'h55;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("af_data", 64'(out_data),  64'(41'h55));
        chk("af_occ",  64'(occupancy), 64'(1));
        step();
        chk("af_drain_occ", 64'(occupancy), 64'(0));

        // Asynchronous reset mid-traffic.
        out_ready = 1'b0;
        push(41'hA);
        push(41'hB);
        chk("mr_pre_occ", 64'(occupancy), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'(0));
        chk("mr_occ",       64'(occupancy), 64'(0));
        chk("mr_out_data",  64'(out_data),  64'(BUBBLE));
        chk("mr_in_ready",  64'(in_ready),  64'(1));
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 41'hC;
        step();
        in_valid = 1'b0;
        chk("mr_post_data", 64'(out_data),  64'(41'hC));
        chk("mr_post_occ",  64'(occupancy), 64'(1));
        out_ready = 1'b1;
        step();
        chk("mr_post_drain", 64'(occupancy), 64'(0));

`ifdef PIPE_SKID_STAGE_PERF_EN
        // Debug clear: flush with in_valid while FULL.
        out_ready = 1'b0;
        push(41'h1);
        push(41'h2);
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("perf_clr_stall",  64'(stall_cnt),  64'(0));
        chk("perf_clr_bubble", 64'(bubble_cnt), 64'(0));
        push(41'h77);
        chk("perf_bubble1", 64'(bubble_cnt), 64'(1));
        for (int i = 0; i < 5; i++) step();
        chk("perf_stall5", 64'(stall_cnt), 64'(5));
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        for (int i = 0; i < 4; i++) step();
        chk("perf_sat", 64'(stall_cnt), 64'(32'hFFFF_FFFF));
        push(41'h78);
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("perf_clr2_stall",  64'(stall_cnt),  64'(0));
        chk("perf_clr2_bubble", 64'(bubble_cnt), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
